// File: rtl/ro_slot_receiver.sv
// ro_slot_receiver
//   Receive end of the gray-slotted readout bus. A local binary slot counter
//   mirrors the transmitters' gray counter. The step c -> c+1 belongs to
//   channel ctz(~c), and that channel drives both shared lines for the cycle
//   that follows. Each owned cycle is sampled into per-channel shadow bits.
//   Samples that are not all-zero (or every sample, when EMIT_ZEROS=1) are
//   queued as timestamped events behind a valid/ready head.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   enable, sync          counter advance enable, synchronous counter realign
//   bus_pol, bus_pol_eve  shared readout lines
//   chan_pol, chan_pol_eve   last sampled bits per channel
//   ev_valid, ev_ready    event FIFO head handshake
//   ev_chan, ev_pol, ev_pol_eve, ev_time   head event fields
//   overflow              sticky flag: an event was dropped on a full FIFO

module ro_slot_receiver #(
    parameter int N_CH       = 16,
    parameter int FIFO_DEPTH = 8,
    parameter bit EMIT_ZEROS = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    sync,
    input  logic                    bus_pol,
    input  logic                    bus_pol_eve,
    output logic [N_CH-1:0]         chan_pol,
    output logic [N_CH-1:0]         chan_pol_eve,
    output logic                    ev_valid,
    input  logic                    ev_ready,
    output logic [$clog2(N_CH)-1:0] ev_chan,
    output logic                    ev_pol,
    output logic                    ev_pol_eve,
    output logic [N_CH-1:0]         ev_time,
    output logic                    overflow
);

    localparam int SW = $clog2(N_CH);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = SW + 2 + N_CH;

    logic [N_CH-1:0] cnt_q, cnt_d;
    logic [SW-1:0]   slot_q, slot_d;
    logic            slot_vld_q, slot_vld_d;
    logic [N_CH-1:0] chan_pol_q, chan_pol_d;
    logic [N_CH-1:0] chan_pol_eve_q, chan_pol_eve_d;
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic [EW-1:0]   last_q, last_d;
    logic            overflow_q, overflow_d;
    logic [EW-1:0]   mem [FIFO_DEPTH];

    logic [SW-1:0]   tz_slot;
    logic            tz_found;
    logic            sample;
    logic            push;
    logic            pop;
    logic            wr_en;
    logic            fifo_empty;
    logic            fifo_full;
    logic [EW-1:0]   head;

    // Owner of the step out of cnt_q: index of the lowest zero bit.
    // All-ones count has no zero bit and is the idle slot.
    always_comb begin
        tz_slot  = '0;
        tz_found = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (!tz_found && !cnt_q[i]) begin
                tz_slot  = i[SW-1:0];
                tz_found = 1'b1;
            end
        end
    end

    // A sync edge realigns the counter and also drops the pending slot sample,
    // since the owner it was decoded for no longer matches the transmitters.
    assign sample = enable && !sync && slot_vld_q;
    assign push   = sample && (bus_pol || bus_pol_eve || EMIT_ZEROS);

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop        = !fifo_empty && ev_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign wr_en      = push && (!fifo_full || pop);

    always_comb begin
        cnt_d      = cnt_q;
        slot_d     = slot_q;
        slot_vld_d = 1'b0;
        if (sync) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d      = cnt_q + 1'b1;
            slot_d     = tz_slot;
            slot_vld_d = tz_found;
        end
    end

    always_comb begin
        chan_pol_d     = chan_pol_q;
        chan_pol_eve_d = chan_pol_eve_q;
        if (sample) begin
            chan_pol_d[slot_q]     = bus_pol;
            chan_pol_eve_d[slot_q] = bus_pol_eve;
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, wr_en};
        rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
        overflow_d = overflow_q || (push && fifo_full && !pop);
        last_d     = last_q;
        if (pop) begin
            last_d = mem[rd_ptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q          <= '0;
            slot_q         <= '0;
            slot_vld_q     <= 1'b0;
            chan_pol_q     <= '0;
            chan_pol_eve_q <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            last_q         <= '0;
            overflow_q     <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            slot_q         <= slot_d;
            slot_vld_q     <= slot_vld_d;
            chan_pol_q     <= chan_pol_d;
            chan_pol_eve_q <= chan_pol_eve_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            last_q         <= last_d;
            overflow_q     <= overflow_d;
        end
    end

    // Storage needs no reset: an empty FIFO presents last_q, never mem.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[AW-1:0]] <= {slot_q, bus_pol, bus_pol_eve, cnt_q};
        end
    end

    // Empty FIFO holds the last accepted head so the fields stay stable.
    assign head = fifo_empty ? last_q : mem[rd_ptr_q[AW-1:0]];

    assign {ev_chan, ev_pol, ev_pol_eve, ev_time} = head;
    assign ev_valid     = !fifo_empty;
    assign chan_pol     = chan_pol_q;
    assign chan_pol_eve = chan_pol_eve_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_ro_slot_receiver.sv
module tb_ro_slot_receiver;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       sync;
    logic       bus_pol;
    logic       bus_pol_eve;
    logic [3:0] chan_pol;
    logic [3:0] chan_pol_eve;
    logic       ev_valid;
    logic       ev_ready;
    logic [1:0] ev_chan;
    logic       ev_pol;
    logic       ev_pol_eve;
    logic [3:0] ev_time;
    logic       overflow;

    ro_slot_receiver #(.N_CH(4), .FIFO_DEPTH(8), .EMIT_ZEROS(1'b0)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sync         (sync),
        .bus_pol      (bus_pol),
        .bus_pol_eve  (bus_pol_eve),
        .chan_pol     (chan_pol),
        .chan_pol_eve (chan_pol_eve),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_chan      (ev_chan),
        .ev_pol       (ev_pol),
        .ev_pol_eve   (ev_pol_eve),
        .ev_time      (ev_time),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    logic [7:0] exp_q[$];     // {chan, pol, pol_eve, time}
    int         n_checks = 0;
    int         n_pass   = 0;
    int         mon_pops = 0;
    logic [3:0] tcnt;         // transmitter counter value during the current cycle

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Channel driving the lines during the cycle whose count is v (v != 0).
    function automatic logic [1:0] owner(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i[1:0];
        return 2'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (sync) tcnt = 4'd0;
        else if (enable) tcnt = tcnt + 4'd1;
        #2;
    endtask

    task automatic drive(input logic p, input logic e, input bit expect_push);
        bus_pol     = p;
        bus_pol_eve = e;
        if (expect_push && (p || e)) exp_q.push_back({owner(tcnt), p, e, tcnt});
    endtask

    task automatic drain(input string name);
        ev_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            tick();
            drive(1'b0, 1'b0, 1'b0);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0);
        chk({name, "_sb_empty"}, exp_q.size(), 0);
        chk({name, "_valid_low"}, ev_valid, 1'b0);
    endtask

    // Scoreboard monitor: an accepted head is compared with the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (ev_valid && ev_ready) begin
                mon_pops++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL ev_unexpected: got chan=%0d pol=%0d eve=%0d time=%0d, required no event",
                             ev_chan, ev_pol, ev_pol_eve, ev_time);
                end else begin
                    chk("ev_head", {24'b0, ev_chan, ev_pol, ev_pol_eve, ev_time}, {24'b0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish before 100us");
        $fatal(1, "watchdog");
    end

    initial begin
        int  pushes;
        bit  done1;
        bit  done8;
        bit  prev_own;
        int  base;

        reset = 1'b1; enable = 1'b0; sync = 1'b0;
        bus_pol = 1'b0; bus_pol_eve = 1'b0; ev_ready = 1'b0;
        tcnt = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", ev_valid, 1'b0);
        chk("rst_chan_pol", chan_pol, 4'h0);
        chk("rst_chan_eve", chan_pol_eve, 4'h0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_head", {ev_chan, ev_pol, ev_pol_eve, ev_time}, 8'h00);
        @(posedge clk); #2;
        reset = 1'b0; enable = 1'b1; ev_ready = 1'b1; tcnt = 4'd0;

        // 1: quiet bus over a full counter period
        for (int i = 0; i < 20; i++) begin
            tick();
            drive(1'b0, 1'b0, 1'b0);
            chk("t1_no_valid", ev_valid, 1'b0);
        end
        chk("t1_chan_pol", chan_pol, 4'h0);
        chk("t1_overflow", overflow, 1'b0);

        // 2: pol in every ch0 slot -> events at odd times
        prev_own = 1'b0;
        for (int i = 0; i < 17; i++) begin
            tick();
            if (prev_own) chk("t2_chan_pol0", chan_pol[0], 1'b1);
            prev_own = (tcnt != 0) && (owner(tcnt) == 2'd0) && (i < 16);
            if (prev_own) drive(1'b1, 1'b0, 1'b1);
            else drive(1'b0, 1'b0, 1'b0);
        end

        // 2b: pol_eve only in ch2 slots
        prev_own = 1'b0;
        for (int i = 0; i < 17; i++) begin
            tick();
            if (prev_own) chk("t2b_chan_eve2", chan_pol_eve, 4'b0100);
            prev_own = (tcnt != 0) && (owner(tcnt) == 2'd2) && (i < 16);
            if (prev_own) drive(1'b0, 1'b1, 1'b1);
            else drive(1'b0, 1'b0, 1'b0);
        end

        // 3: ch3 slot (count 7 -> 8) gives one event at time 8; idle slot driven but ignored
        prev_own = 1'b0;
        for (int i = 0; i < 17; i++) begin
            tick();
            if (prev_own) chk("t3_chan_pol", chan_pol, 4'b1000);
            prev_own = (tcnt == 4'd8);
            if (tcnt == 4'd0) begin
                drive(1'b1, 1'b1, 1'b0);
            end else if (tcnt == 4'd8) begin
                drive(1'b1, 1'b0, 1'b0);
                exp_q.push_back(8'b11_1_0_1000);
            end else begin
                drive(1'b0, 1'b0, 1'b0);
            end
        end
        drain("t3");

        // enable low: counter holds, nothing sampled even with the bus active
        enable = 1'b0;
        drive(1'b1, 1'b1, 1'b0);
        repeat (3) tick();
        chk("ten_chan_eve", chan_pol_eve, 4'h0);
        chk("ten_no_valid", ev_valid, 1'b0);
        enable = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        tick();

        // 4: consumer stalled, every slot active -> 8 stored, 9th dropped
        ev_ready = 1'b0;
        pushes = 0; done1 = 1'b0; done8 = 1'b0;
        while (pushes < 9) begin
            tick();
            if (pushes == 1 && !done1) begin chk("t4_valid_first", ev_valid, 1'b1); done1 = 1'b1; end
            if (pushes == 8 && !done8) begin chk("t4_no_ovf_at_8", overflow, 1'b0); done8 = 1'b1; end
            if (tcnt != 0) begin
                drive(1'b1, tcnt[1], pushes < 8);
                pushes++;
            end else begin
                drive(1'b0, 1'b0, 1'b0);
            end
        end
        tick();
        drive(1'b0, 1'b0, 1'b0);
        chk("t4_ovf_on_9", overflow, 1'b1);
        drain("t4");
        chk("t4_ovf_sticky", overflow, 1'b1);

        reset = 1'b1;
        #1 chk("rst2_overflow", overflow, 1'b0);
        @(posedge clk); #2;
        reset = 1'b0; tcnt = 4'd0;

        // 5: full FIFO, push and pop on the same edge -> no overflow, 8 remain
        ev_ready = 1'b0;
        pushes = 0;
        while (pushes < 9) begin
            tick();
            ev_ready = 1'b0;
            if (tcnt == 0) begin
                drive(1'b0, 1'b0, 1'b0);
            end else begin
                if (pushes == 8) ev_ready = 1'b1;
                drive(1'b1, ~tcnt[0], 1'b1);
                pushes++;
            end
        end
        tick();
        ev_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        chk("t5_no_ovf", overflow, 1'b0);
        chk("t5_valid", ev_valid, 1'b1);
        base = mon_pops;
        drain("t5");
        chk("t5_drained_8", mon_pops - base, 8);

        // 6: reset with 3 events queued, then sync realign
        ev_ready = 1'b0;
        pushes = 0;
        while (pushes < 3) begin
            tick();
            if (tcnt != 0) begin drive(1'b1, 1'b0, 1'b1); pushes++; end
            else drive(1'b0, 1'b0, 1'b0);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0);
        chk("t6_queued", ev_valid, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk("t6_rst_valid", ev_valid, 1'b0);
        chk("t6_rst_chan_pol", chan_pol, 4'h0);
        chk("t6_rst_head", {ev_chan, ev_pol, ev_pol_eve, ev_time}, 8'h00);
        exp_q.delete();
        @(posedge clk); #2;
        reset = 1'b0; tcnt = 4'd0;

        tick();                                   // count 1, ch0
        drive(1'b1, 1'b0, 1'b0);
        exp_q.push_back(8'b00_1_0_0001);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        sync = 1'b1;
        tick();
        sync = 1'b0;
        chk("t6_sync_tcnt_model", {28'b0, tcnt}, 32'd0);
        chk("t6_sync_keeps_fifo", ev_valid, 1'b1);
        ev_ready = 1'b1;
        tick();                                   // count 1 after realign, ch0
        drive(1'b0, 1'b1, 1'b0);
        exp_q.push_back(8'b00_0_1_0001);
        tick();                                   // count 2, ch1
        drive(1'b1, 1'b1, 1'b0);
        exp_q.push_back(8'b01_1_1_0010);
        drain("t6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
